// File: rtl/mem_arbiter_pkg.sv
// Shared types for the RAM port arbiter: bus word, RAM handshake state and arbiter FSM state.
package mem_arbiter_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    INSTR = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single RAM port shared by the data path and two instruction fetch ports.
// Data normally wins; fetches are round-robin; a starve counter forces a fetch slot.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            dREN,
  input  logic            dWEN,
  input  word_t           daddr,
  input  word_t           dstore,
  output logic            dwait,
  output word_t           dload,
  input  logic [1:0]      iREN,
  input  word_t [1:0]     iaddr,
  output logic [1:0]      iwait,
  output word_t [1:0]     iload,
  output logic            ramREN,
  output logic            ramWEN,
  output word_t           ramaddr,
  output word_t           ramstore,
  input  word_t           ramload,
  input  ramstate_t       ramstate
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t       state, state_next;
  logic             gnt_core, gnt_core_next;
  logic             rr_ptr, rr_ptr_next;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_next;

  logic d_req, i_any, starved, pick;

  assign d_req   = dREN | dWEN;
  assign i_any   = |iREN;
  assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));
  // Both cores asking: honour the round-robin pointer; otherwise the lone requester.
  assign pick    = (&iREN) ? rr_ptr : iREN[1];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      gnt_core   <= 1'b0;
      rr_ptr     <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      gnt_core   <= gnt_core_next;
      rr_ptr     <= rr_ptr_next;
      starve_cnt <= starve_cnt_next;
    end
  end

  always_comb begin
    state_next      = state;
    gnt_core_next   = gnt_core;
    rr_ptr_next     = rr_ptr;
    starve_cnt_next = starve_cnt;
    ramREN          = 1'b0;
    ramWEN          = 1'b0;
    ramaddr         = '0;
    ramstore        = '0;
    dwait           = 1'b1;
    iwait           = 2'b11;
    dload           = '0;
    iload           = '0;

    case (state)
      IDLE: begin
        if (starved && i_any) begin
          state_next    = INSTR;
          gnt_core_next = pick;
        end else if (d_req) begin
          state_next    = DATA;
        end else if (i_any) begin
          state_next    = INSTR;
          gnt_core_next = pick;
        end
      end

      DATA: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (!d_req) begin
          state_next = IDLE;
        end else if (ramstate == ACCESS) begin
          dwait      = 1'b0;
          dload      = ramload;
          state_next = IDLE;
          if (i_any) begin
            starve_cnt_next = starved ? starve_cnt : starve_cnt + CNT_W'(1);
          end else begin
            starve_cnt_next = '0;
          end
        end
      end

      INSTR: begin
        ramaddr = iaddr[gnt_core];
        // Losing the request mid-flight drops the enable and abandons the slot.
        if (!iREN[gnt_core]) begin
          state_next = IDLE;
        end else begin
          ramREN = 1'b1;
          if (ramstate == ACCESS) begin
            iwait[gnt_core] = 1'b0;
            iload[gnt_core] = ramload;
            rr_ptr_next     = ~gnt_core;
            starve_cnt_next = '0;
            state_next      = IDLE;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus multi-cycle sequences,
// with completions checked against a scoreboard of expected load values.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        dREN, dWEN;
  word_t       daddr, dstore;
  logic        dwait;
  word_t       dload;
  logic [1:0]  iREN;
  word_t [1:0] iaddr;
  logic [1:0]  iwait;
  word_t [1:0] iload;
  logic        ramREN, ramWEN;
  word_t       ramaddr, ramstore, ramload;
  ramstate_t   ramstate;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0] kind;   // 0 data, 1 core0, 2 core1
    word_t      val;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic       dren;
    logic       dwen;
    logic [1:0] iren;
    ramstate_t  rs;
    logic       ren;
    logic       wen;
    word_t      addr;
    word_t      store;
    logic       dw;
    logic [1:0] iw;
  } vec_t;
  vec_t vt[12];

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  function automatic word_t mem_f(input word_t a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return (a ^ 32'hC3C3_0000) + 32'h0000_0011;
  endfunction

  assign ramload = mem_f(ramaddr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] kind, input word_t val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    sbq.push_back(e);
  endtask

  task automatic pop_check(input logic [1:0] kind, input word_t val);
    exp_t e;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_extra: got completion kind %0d data %h want none at %0t", kind, val, $time);
    end else begin
      e = sbq.pop_front();
      check("sb_kind", 32'(kind), 32'(e.kind));
      check("sb_data", val, e.val);
    end
  endtask

  // Completion monitor, sampled mid-cycle.
  always @(negedge CLK) begin
    if (nRST) begin
      if (!dwait) pop_check(2'd0, dload);
      for (int k = 0; k < 2; k++)
        if (!iwait[k]) pop_check(2'(k + 1), iload[k]);
    end
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic drop_all();
    dREN = 1'b0; dWEN = 1'b0; iREN = 2'b00; ramstate = FREE;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    drop_all();
    next_cycle();
    nRST = 1'b1;
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b1, 1'b0, 2'b00, ACCESS, 1'b1, 1'b0, 32'h200,  32'h5555AAAA, 1'b0, 2'b11};
    vt[1]  = '{1'b1, 1'b1, 2'b00, BUSY,   1'b0, 1'b1, 32'h200,  32'h5555AAAA, 1'b1, 2'b11};
    vt[2]  = '{1'b0, 1'b1, 2'b00, ACCESS, 1'b0, 1'b1, 32'h200,  32'h5555AAAA, 1'b0, 2'b11};
    vt[3]  = '{1'b0, 1'b0, 2'b01, ACCESS, 1'b1, 1'b0, 32'h1000, 32'h0,        1'b1, 2'b10};
    vt[4]  = '{1'b0, 1'b0, 2'b10, ACCESS, 1'b1, 1'b0, 32'h2000, 32'h0,        1'b1, 2'b01};
    vt[5]  = '{1'b0, 1'b0, 2'b11, ACCESS, 1'b1, 1'b0, 32'h1000, 32'h0,        1'b1, 2'b10};
    vt[6]  = '{1'b0, 1'b0, 2'b11, ACCESS, 1'b1, 1'b0, 32'h2000, 32'h0,        1'b1, 2'b01};
    vt[7]  = '{1'b1, 1'b0, 2'b11, ACCESS, 1'b1, 1'b0, 32'h200,  32'h5555AAAA, 1'b0, 2'b11};
    vt[8]  = '{1'b0, 1'b0, 2'b11, FREE,   1'b1, 1'b0, 32'h1000, 32'h0,        1'b1, 2'b11};
    vt[9]  = '{1'b0, 1'b0, 2'b01, ERROR,  1'b1, 1'b0, 32'h1000, 32'h0,        1'b1, 2'b11};
    vt[10] = '{1'b1, 1'b0, 2'b00, ACCESS, 1'b1, 1'b0, 32'h200,  32'h5555AAAA, 1'b0, 2'b11};
    vt[11] = '{1'b0, 1'b0, 2'b10, BUSY,   1'b1, 1'b0, 32'h2000, 32'h0,        1'b1, 2'b11};

    daddr    = 32'h200;
    dstore   = 32'h5555AAAA;
    iaddr[0] = 32'h1000;
    iaddr[1] = 32'h2000;
    nRST     = 1'b0;
    drop_all();
    #2;
    check("rst_dwait",  32'(dwait),  32'd1);
    check("rst_iwait",  32'(iwait),  32'd3);
    check("rst_ren",    32'(ramREN), 32'd0);
    check("rst_wen",    32'(ramWEN), 32'd0);
    check("rst_addr",   ramaddr,     32'd0);
    check("rst_dload",  dload,       32'd0);
    next_cycle();
    nRST = 1'b1;
    next_cycle();

    // Vector table: each entry is a request from IDLE, checked in its grant cycle.
    for (int v = 0; v < 12; v++) begin
      dREN = vt[v].dren; dWEN = vt[v].dwen; iREN = vt[v].iren; ramstate = vt[v].rs;
      #1;
      check("vec_idle_en", 32'(ramREN | ramWEN), 32'd0);
      next_cycle();
      if (vt[v].rs == ACCESS) begin
        if (!vt[v].dw)         push(2'd0, mem_f(vt[v].addr));
        else if (!vt[v].iw[0]) push(2'd1, mem_f(vt[v].addr));
        else                   push(2'd2, mem_f(vt[v].addr));
      end
      #1;
      check("vec_ren",   32'(ramREN), 32'(vt[v].ren));
      check("vec_wen",   32'(ramWEN), 32'(vt[v].wen));
      check("vec_addr",  ramaddr,     vt[v].addr);
      check("vec_store", ramstore,    vt[v].store);
      check("vec_dwait", 32'(dwait),  32'(vt[v].dw));
      check("vec_iwait", 32'(iwait),  32'(vt[v].iw));
      next_cycle();
      drop_all();
      next_cycle();
    end

    // Data read with two BUSY cycles before ACCESS.
    dREN = 1'b1; daddr = 32'h100; ramstate = BUSY;
    next_cycle();
    check("rd_addr0", ramaddr, 32'h100);
    check("rd_wait0", 32'(dwait), 32'd1);
    next_cycle();
    check("rd_addr1", ramaddr, 32'h100);
    check("rd_wait1", 32'(dwait), 32'd1);
    ramstate = ACCESS;
    push(2'd0, 32'hDEAD_BEEF);
    #1;
    check("rd_done", 32'(dwait), 32'd0);
    check("rd_load", dload, 32'hDEAD_BEEF);
    check("rd_addr2", ramaddr, 32'h100);
    next_cycle();
    check("rd_after", 32'(dwait), 32'd1);
    drop_all();
    daddr = 32'h200;
    next_cycle();

    // Abort: request dropped while BUSY returns to IDLE without a pulse.
    dREN = 1'b1; ramstate = BUSY;
    next_cycle();
    check("ab_ren_on", 32'(ramREN), 32'd1);
    dREN = 1'b0;
    #1;
    check("ab_ren_off", 32'(ramREN), 32'd0);
    next_cycle();
    dREN = 1'b1; ramstate = ACCESS;
    #1;
    check("ab_idle_ren", 32'(ramREN), 32'd0);
    check("ab_idle_dw",  32'(dwait),  32'd1);
    next_cycle();
    push(2'd0, mem_f(32'h200));
    #1;
    check("ab_retry", 32'(dwait), 32'd0);
    next_cycle();
    drop_all();
    next_cycle();

    // ERROR is never treated as completion.
    dREN = 1'b1; ramstate = ERROR;
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      check("err_dwait", 32'(dwait), 32'd1);
      check("err_ren",   32'(ramREN), 32'd1);
      next_cycle();
    end
    ramstate = ACCESS;
    push(2'd0, mem_f(32'h200));
    #1;
    check("err_done", 32'(dwait), 32'd0);
    next_cycle();
    drop_all();
    next_cycle();

    // Round-robin with both cores requesting and RAM always ready.
    do_reset();
    iREN = 2'b11; ramstate = ACCESS;
    for (int n = 0; n < 4; n++)
      push((n % 2 == 0) ? 2'd1 : 2'd2, mem_f((n % 2 == 0) ? 32'h1000 : 32'h2000));
    for (int c = 1; c <= 8; c++) begin
      #1;
      if (c % 2 == 1) check("rr_iwait", 32'(iwait), 32'd3);
      else            check("rr_iwait", 32'(iwait), (c % 4 == 2) ? 32'd2 : 32'd1);
      check("rr_dwait", 32'(dwait), 32'd1);
      next_cycle();
    end
    drop_all();
    next_cycle();

    // Starvation: four data grants, one forced fetch for core 1, then data again.
    do_reset();
    dREN = 1'b1; iREN = 2'b10; ramstate = ACCESS;
    for (int n = 0; n < 6; n++) begin
      if (n == 4) push(2'd2, mem_f(32'h2000));
      else        push(2'd0, mem_f(32'h200));
    end
    for (int c = 1; c <= 12; c++) begin
      #1;
      if (c == 10) begin
        check("sv_dwait", 32'(dwait), 32'd1);
        check("sv_iwait", 32'(iwait), 32'd1);
      end else if (c % 2 == 0) begin
        check("sv_dwait", 32'(dwait), 32'd0);
        check("sv_iwait", 32'(iwait), 32'd3);
      end else begin
        check("sv_dwait", 32'(dwait), 32'd1);
        check("sv_iwait", 32'(iwait), 32'd3);
      end
      next_cycle();
    end
    drop_all();
    next_cycle();

    // Asynchronous reset in the middle of a data transaction.
    dREN = 1'b1; ramstate = BUSY;
    next_cycle();
    check("ar_ren_on", 32'(ramREN), 32'd1);
    #1 nRST = 1'b0;
    #1;
    check("ar_ren",   32'(ramREN), 32'd0);
    check("ar_dwait", 32'(dwait),  32'd1);
    check("ar_addr",  ramaddr,     32'd0);
    ramstate = ACCESS;
    next_cycle();
    #1 nRST = 1'b1;
    #1;
    check("ar_idle_ren", 32'(ramREN), 32'd0);
    check("ar_idle_dw",  32'(dwait),  32'd1);
    next_cycle();
    push(2'd0, mem_f(32'h200));
    #1;
    check("ar_done", 32'(dwait), 32'd0);
    next_cycle();
    drop_all();
    next_cycle();
    next_cycle();

    check("sb_left", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
